// File: rtl/hopfield_update_pkg.sv
// rtl/hopfield_update_pkg.sv - shared constants, state type and load helper for hopfield_update
package hopfield_update_pkg;

  localparam int N_NEURONS = 20;
  localparam int W_WIDTH   = 10;
  localparam int X_WIDTH   = 2;
  localparam int X_BITS    = N_NEURONS * X_WIDTH;
  localparam int IDX_W     = 5;

  localparam logic [X_WIDTH-1:0] NEURON_POS = 2'b01;
  localparam logic [X_WIDTH-1:0] NEURON_NEG = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EVAL,
    DONE
  } state_t;

  // Only the sign bit of each raw neuron field matters; the low bit is rebuilt.
  function automatic logic [X_BITS-1:0] normalise(input logic [X_BITS-1:0] raw);
    logic [X_BITS-1:0] r;
    r = '0;
    for (int j = 0; j < N_NEURONS; j++) begin
      r[j*X_WIDTH +: X_WIDTH] = raw[j*X_WIDTH+1] ? NEURON_NEG : NEURON_POS;
    end
    return r;
  endfunction

endpackage

// File: rtl/hopfield_update.sv
// rtl/hopfield_update.sv - asynchronous Hopfield recall sequencer
// Fetches one weight row per neuron, updates that neuron from y, repeats sweeps until stable or limit.
module hopfield_update
  import hopfield_update_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [X_BITS-1:0]  init_state,
  input  logic [7:0]         max_sweeps,
  output logic               row_req,
  output logic [IDX_W-1:0]   row_idx,
  input  logic               row_valid,
  output logic [X_BITS-1:0]  xalt_packed,
  input  logic [W_WIDTH-1:0] y,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [7:0]         sweep_cnt
);

  state_t             state_q, state_d;
  logic [X_BITS-1:0]  x_q, x_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         sweep_q, sweep_d;
  logic [7:0]         limit_q, limit_d;
  logic               change_q, change_d;
  logic               conv_q, conv_d;

  logic [X_WIDTH-1:0] cur_val;
  logic [X_WIDTH-1:0] new_val;
  logic               chg_any;
  logic [7:0]         sweep_inc;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    idx_d    = idx_q;
    sweep_d  = sweep_q;
    limit_d  = limit_q;
    change_d = change_q;
    conv_d   = conv_q;

    cur_val   = x_q[int'(idx_q)*X_WIDTH +: X_WIDTH];
    // y is plain 10-bit two's complement; zero leaves the neuron untouched.
    if (y == '0) begin
      new_val = cur_val;
    end else if (y[W_WIDTH-1]) begin
      new_val = NEURON_NEG;
    end else begin
      new_val = NEURON_POS;
    end
    chg_any   = change_q | (new_val != cur_val);
    sweep_inc = sweep_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d      = normalise(init_state);
          limit_d  = (max_sweeps == 8'd0) ? 8'd1 : max_sweeps;
          idx_d    = '0;
          sweep_d  = '0;
          change_d = 1'b0;
          conv_d   = 1'b0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (row_valid) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        x_d[int'(idx_q)*X_WIDTH +: X_WIDTH] = new_val;
        change_d = chg_any;
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          sweep_d = sweep_inc;
          if (!chg_any) begin
            conv_d  = 1'b1;
            state_d = DONE;
          end else if (sweep_inc == limit_q) begin
            conv_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d    = '0;
            change_d = 1'b0;
            state_d  = FETCH;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= {N_NEURONS{NEURON_POS}};
      idx_q    <= '0;
      sweep_q  <= '0;
      limit_q  <= 8'd1;
      change_q <= 1'b0;
      conv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      idx_q    <= idx_d;
      sweep_q  <= sweep_d;
      limit_q  <= limit_d;
      change_q <= change_d;
      conv_q   <= conv_d;
    end
  end

  assign row_req     = (state_q == FETCH);
  assign row_idx     = idx_q;
  assign xalt_packed = x_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign converged   = conv_q;
  assign sweep_cnt   = sweep_q;

endmodule

// File: doc/hopfield_update.md
HOPFIELD_UPDATE -- requirements
Module: hopfield_update

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 start  in  1  begin a recall run; sampled only in IDLE.
REQ-005 init_state  in  40  initial pattern, 20 neurons x 2 bits, neuron j at bits [2j+1:2j]; loaded on accepted start.
REQ-006 max_sweeps  in  8  sweep limit, sampled on accepted start.
REQ-007 row_req  out  1  request weight row row_idx from the weight store.
REQ-008 row_idx  out  5  neuron index 0..19 whose weight row is requested.
REQ-009 row_valid  in  1  weight row row_idx is present on the weight bus to the prediction stage.
REQ-010 xalt_packed  out  40  current neuron states, driven to the prediction stage.
REQ-011 y  in  10  signed weighted sum from the prediction stage, combinational on xalt_packed and weights.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  one-cycle pulse at run end.
REQ-014 converged  out  1  valid from done until the next accepted start; 1 means the last sweep changed no neuron.
REQ-015 sweep_cnt  out  8  completed sweeps in the current or last run.

Function
REQ-016 Neuron encoding SHALL be +1 = 2'b01 and -1 = 2'b11; on load, init bit[2j+1]=1 gives -1 and 0 gives +1.
REQ-017 FSM states SHALL be IDLE, FETCH, EVAL and DONE.
REQ-018 IDLE with start=1 SHALL: load normalised init_state; latch max_sweeps, treating 0 as 1; clear idx, sweep_cnt, change flag and converged; go to FETCH.
REQ-019 FETCH SHALL drive row_req=1 with row_idx=idx, wait indefinitely for row_valid, and go to EVAL on the first cycle with row_valid=1.
REQ-020 The upstream weight store SHALL hold the weight bus stable from the row_valid cycle through the following EVAL cycle; row_req SHALL be 0 in EVAL.
REQ-021 EVAL SHALL sample y as signed and update neuron idx: y>0 gives +1, y<0 gives -1, y==0 keeps the current value.
REQ-022 EVAL SHALL set the sweep change flag if neuron idx changed value.
REQ-023 The sum SHALL be taken as the 10-bit two's-complement y as delivered: no saturation and no overflow recovery.
REQ-024 EVAL with idx<19 SHALL increment idx and go to FETCH.
REQ-025 EVAL with idx==19 SHALL increment sweep_cnt, then choose the next state:
- change flag clear (including the change from this cycle): converged=1, go to DONE;
- otherwise, incremented sweep_cnt equals the latched limit: converged=0, go to DONE;
- otherwise: idx=0, clear the change flag, go to FETCH.
REQ-026 DONE SHALL assert done for exactly one cycle and then go to IDLE; xalt_packed, sweep_cnt and converged SHALL hold until the next accepted start.
REQ-027 start outside IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-028 The update order SHALL be asynchronous Hopfield: neuron j's update SHALL be visible on xalt_packed before row j+1 is evaluated.
REQ-029 With row_valid tied high, one sweep SHALL take exactly 40 cycles (FETCH+EVAL per neuron).
REQ-030 Outputs row_req, busy, done and converged SHALL be registered or decoded only from registered state, with no combinational path from inputs.

Reset
REQ-031 On rst: state=IDLE, xalt_packed = all +1 (40'h5555555555), idx=0, sweep_cnt=0, change flag=0, converged=0, done=0, row_req=0, busy=0.
REQ-032 rst mid-run SHALL abort immediately to the REQ-031 values, with no done pulse.

Structure
REQ-033 A shared package SHALL hold N_NEURONS=20, W_WIDTH=10, X_WIDTH=2, the constants NEURON_POS=2'b01 and NEURON_NEG=2'b11, and the FSM state type.
REQ-034 The block SHALL contain no sub-module; it is instantiated beside the prediction stage and the weight store at the recall top level.

Verification
REQ-035 Reset check: assert rst mid-FETCH -> xalt_packed=40'h5555555555, busy=0, row_req=0, no done pulse.
REQ-036 Stable pattern: identity-like weights with the pattern stored, init equal to that pattern, row_valid=1 -> done 40 cycles after the start-accept edge, converged=1, sweep_cnt=1.
REQ-037 One-bit-corrupted stored pattern -> neuron restored in sweep 1; done after sweep 2 with converged=1, sweep_cnt=2.
REQ-038 Oscillating weights with max_sweeps=3 -> done with converged=0, sweep_cnt=3; max_sweeps=0 -> sweep_cnt=1.
REQ-039 y==0 forced for neuron 5, which stays -1; y=10'sh200 (-512) -> neuron set to -1.
REQ-040 Handshake stress: row_valid stalled 0..7 random cycles per row, start pulsed while busy -> final state identical to the no-stall run and start ignored.
